// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the Otter RV32I execute-stage ALU. The decoder and the
// control unit import this package for every func encoding.
//   XLEN        : datapath width (32)
//   ALU_POISON  : value driven on unused func codes when ALU_POISON_EN is defined
//   alu_func_e  : 4-bit ALU operation select
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] ALU_POISON = 32'hDEAD_DEAD;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_LUI  = 4'b1001,
      ALU_SRA  = 4'b1101
   } alu_func_e;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Barrel shifter shared by SLL, SRL and SRA.
// Ports:
//   i_a       in  32 : word to shift
//   i_amt     in   5 : shift amount (0..31)
//   i_right   in   1 : 1 = shift right, 0 = shift left
//   i_arith   in   1 : with i_right, fill vacated bits with i_a[31]
//   o_y       out 32 : shifted word
// -----------------------------------------------------------------------------
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [4:0]      i_amt,
   input  logic            i_right,
   input  logic            i_arith,
   output logic [XLEN-1:0] o_y
);

   // Select shift direction and fill; i_arith has no effect on left shifts
   always_comb begin
      o_y = {XLEN{1'b0}};
      if (i_right) begin
         if (i_arith) begin
            o_y = $unsigned($signed(i_a) >>> i_amt);
         end else begin
            o_y = i_a >> i_amt;
         end
      end else begin
         o_y = i_a << i_amt;
      end
   end

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// 32-bit RV32I integer ALU for the Otter execute stage. result is purely
// combinational; result_q is a registered copy for pipelined consumers.
// Ports:
//   clk       in   1 : rising-edge clock (only result_q uses it)
//   rst_n     in   1 : asynchronous active-low reset, clears result_q
//   src_a     in  32 : operand A, also the LUI source
//   src_b     in  32 : operand B, shift amount in [4:0]
//   func      in   4 : operation select (alu_func_e)
//   result    out 32 : combinational result
//   result_q  out 32 : result registered on rising clk
// Configuration macro:
//   ALU_POISON_EN : when defined, unused func codes drive 32'hDEADDEAD;
//                   otherwise they drive zero.
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [3:0]      func,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] result_q
);

`ifdef ALU_POISON_EN
   localparam logic [XLEN-1:0] UNUSED_VAL = ALU_POISON;
`else
   localparam logic [XLEN-1:0] UNUSED_VAL = 32'h0000_0000;
`endif

   logic [XLEN-1:0] w_b_op;
   logic            w_sub;
   logic [XLEN-1:0] w_addsub;
   logic            w_slt;
   logic            w_sltu;
   logic            w_sh_right;
   logic            w_sh_arith;
   logic [XLEN-1:0] w_shift;
   logic [XLEN-1:0] r_result_q;

   // One adder serves ADD and SUB: A - B = A + ~B + 1
   assign w_sub    = (func == ALU_SUB);
   assign w_b_op   = w_sub ? ~src_b : src_b;
   assign w_addsub = src_a + w_b_op + {31'd0, w_sub};

   assign w_slt  = ($signed(src_a) < $signed(src_b));
   assign w_sltu = (src_a < src_b);

   assign w_sh_right = (func == ALU_SRL) || (func == ALU_SRA);
   assign w_sh_arith = (func == ALU_SRA);

   alu_shifter u_shifter (
      .i_a     (src_a),
      .i_amt   (src_b[4:0]),
      .i_right (w_sh_right),
      .i_arith (w_sh_arith),
      .o_y     (w_shift)
   );

   // Output mux: every func code, including unused ones, drives a defined value
   always_comb begin
      result = UNUSED_VAL;
      case (func)
         ALU_ADD  : result = w_addsub;
         ALU_SUB  : result = w_addsub;
         ALU_SLL  : result = w_shift;
         ALU_SRL  : result = w_shift;
         ALU_SRA  : result = w_shift;
         ALU_SLT  : result = {31'd0, w_slt};
         ALU_SLTU : result = {31'd0, w_sltu};
         ALU_XOR  : result = src_a ^ src_b;
         ALU_OR   : result = src_a | src_b;
         ALU_AND  : result = src_a & src_b;
         ALU_LUI  : result = src_a;
         default  : result = UNUSED_VAL;
      endcase
   end

   // Pipeline copy of result; reset clears it without waiting for a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result_q <= 32'h0000_0000;
      end else begin
         r_result_q <= result;
      end
   end

   assign result_q = r_result_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
   import alu_pkg::*;

`ifdef ALU_POISON_EN
   localparam logic [31:0] EXP_UNUSED = 32'hDEAD_DEAD;
`else
   localparam logic [31:0] EXP_UNUSED = 32'h0000_0000;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  f;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [3:0]  func;
   logic [31:0] result;
   logic [31:0] result_q;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sb_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_a    (src_a),
      .src_b    (src_b),
      .func     (func),
      .result   (result),
      .result_q (result_q)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pop the oldest scoreboard entry and compare it with result_q
   task automatic check_q(input string name);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         check(name, result_q, sb_q.pop_front());
      end
   endtask

   // Drive one operation at negedge, check comb result, then registered copy
   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [31:0] exp, input string name);
      @(negedge clk);
      src_a = a;
      src_b = b;
      func  = f;
      #1;
      check({name, "_comb"}, result, exp);
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      check_q({name, "_q"});
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, ALU_ADD,  32'h9999_9999});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD,  32'h0000_0000});
      vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD,  32'h8000_0000});
      vecs.push_back('{32'h8765_4321, 32'h1234_5678, ALU_SUB,  32'h7530_ECA9});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, ALU_SUB,  32'h8ACF_1357});
      vecs.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, ALU_OR,   32'hFFFF_FFFF});
      vecs.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, ALU_AND,  32'h0000_0000});
      vecs.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, ALU_XOR,  32'hFFFF_FFFF});
      vecs.push_back('{32'h1234_5678, 32'h1234_5678, ALU_XOR,  32'h0000_0000});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, ALU_LUI,  32'h1234_5678});
      vecs.push_back('{32'h8000_0000, 32'h0000_0001, ALU_SRL,  32'h4000_0000});
      vecs.push_back('{32'h8000_0000, 32'h0000_001F, ALU_SRL,  32'h0000_0001});
      vecs.push_back('{32'h8000_0000, 32'h0000_0021, ALU_SRL,  32'h4000_0000});
      vecs.push_back('{32'h1234_5678, 32'h0000_0000, ALU_SRL,  32'h1234_5678});
      vecs.push_back('{32'h0000_0001, 32'h0000_001F, ALU_SLL,  32'h8000_0000});
      vecs.push_back('{32'h0000_0001, 32'h0000_0024, ALU_SLL,  32'h0000_0010});
      vecs.push_back('{32'h1234_5678, 32'h0000_0000, ALU_SLL,  32'h1234_5678});
      vecs.push_back('{32'h8000_0000, 32'h0000_0001, ALU_SRA,  32'hC000_0000});
      vecs.push_back('{32'h8000_0000, 32'h0000_001F, ALU_SRA,  32'hFFFF_FFFF});
      vecs.push_back('{32'h4000_0000, 32'h0000_0001, ALU_SRA,  32'h2000_0000});
      vecs.push_back('{32'h8765_4321, 32'h0000_0000, ALU_SRA,  32'h8765_4321});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT,  32'h0000_0001});
      vecs.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFFF, ALU_SLT,  32'h0000_0001});
      vecs.push_back('{32'h0000_0005, 32'h0000_0005, ALU_SLT,  32'h0000_0000});
      vecs.push_back('{32'h0000_0001, 32'hFFFF_FFFF, ALU_SLT,  32'h0000_0000});
      vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, ALU_SLTU, 32'h0000_0001});
      vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, ALU_SLTU, 32'h0000_0000});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, ALU_SLTU, 32'h0000_0000});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, 4'b1111,  EXP_UNUSED});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, 4'b1010,  EXP_UNUSED});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, 4'b1011,  EXP_UNUSED});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, 4'b1100,  EXP_UNUSED});
      vecs.push_back('{32'h1234_5678, 32'h8765_4321, 4'b1110,  EXP_UNUSED});

      // Load a nonzero value, then reset asynchronously between edges
      rst_n = 1'b1;
      src_a = 32'h0000_0005;
      src_b = 32'h0000_0000;
      func  = ALU_ADD;
      @(posedge clk);
      #1;
      check("q_preload", result_q, 32'h0000_0005);
      #2;
      rst_n = 1'b0;
      #1;
      check("q_async_clear", result_q, 32'h0000_0000);
      check("comb_during_reset", result, 32'h0000_0005);
      @(posedge clk);
      #1;
      check("q_held_in_reset", result_q, 32'h0000_0000);

      // Release with ADD 1+2 applied; first edge loads 3
      @(negedge clk);
      rst_n = 1'b1;
      src_a = 32'h0000_0001;
      src_b = 32'h0000_0002;
      func  = ALU_ADD;
      sb_q.push_back(32'h0000_0003);
      @(posedge clk);
      #1;
      check_q("q_first_after_release");

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp, $sformatf("vec%0d_f%b", i, vecs[i].f));
      end

      // Mid-stream reset between edges, then resume
      drive(32'h1234_5678, 32'h8765_4321, ALU_ADD, 32'h9999_9999, "mid_pre");
      #2;
      rst_n = 1'b0;
      #1;
      check("q_mid_async_clear", result_q, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      src_a = 32'h8765_4321;
      src_b = 32'h1234_5678;
      func  = ALU_SUB;
      sb_q.push_back(32'h7530_ECA9);
      @(posedge clk);
      #1;
      check_q("q_resume_after_mid_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
